// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front-end: synchronizes the raw rx pin, deserializes one
// frame at a time and presents the byte through a level valid/ack handshake.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk_raw,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            load;

  // Two-flop synchronizer; both stages reset to the idle-high line level.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM, counters, shift register and handshake state.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: mid-bit sampling, stop-bit checking and valid/ack handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            // Glitch shorter than half a bit: drop it silently.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntBit) begin
          shreg_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntBit) begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          state_d = StIdle;
          cnt_d   = '0;
          if (rx_s_q) begin
            load = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A load in the same cycle as an ack wins over the ack.
    if (load) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else if (rx_ack) begin
        overrun_d = 1'b0;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    // Busy rises one edge after START is entered and falls on the exit edge.
    busy_d = (state_q != StIdle) && (state_d != StIdle);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed frames, expected frame outcomes queued
// at issue time and checked by a monitor when the DUT ends each frame.
module tb_uart_rx_frontend;

  localparam int unsigned CPB = 8;

  logic       clk_raw = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk_raw = ~clk_raw;

  uart_rx_frontend #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_raw  (clk_raw),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model of the output registers, updated when stimulus is issued.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind 0 = good frame carrying b, 1 = stop-bit error, 2 = false start
  task automatic push(input string name, input int kind, input logic [7:0] b);
    exp_t x;
    if (kind == 0) begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end
    x.name  = name;
    x.data  = m_data;
    x.valid = m_valid;
    x.ferr  = (kind == 1);
    x.ovr   = m_ovr;
    sb.push_back(x);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk_raw);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk_raw);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk_raw);
      #1;
      k++;
    end
    check({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clk_raw);
    #1;
    rx_ack  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Monitor: each busy falling edge ends a frame; compare against the queue head.
  logic busy_prev   = 1'b0;
  logic ferr_follow = 1'b0;
  always @(negedge clk_raw) begin
    if (!rst_n) begin
      busy_prev   = 1'b0;
      ferr_follow = 1'b0;
    end else begin
      if (ferr_follow) begin
        check("ferr_width", frame_err, 0);
        ferr_follow = 1'b0;
      end
      if (busy_prev && !rx_busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_end: got data %0h with empty queue", rx_data);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, rx_data, e.data);
          check({e.name, "_valid"}, rx_valid, e.valid);
          check({e.name, "_ferr"}, frame_err, e.ferr);
          check({e.name, "_ovr"}, overrun, e.ovr);
          if (e.ferr) ferr_follow = 1'b1;
        end
      end else if (frame_err) begin
        check("ferr_outside_frame_end", frame_err, 0);
      end
      busy_prev = rx_busy;
    end
  end

  initial begin
    // Reset with rx toggling: all outputs held at zero.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_raw);
      #1;
      rx = ~rx;
      check("rst_outs", {rx_data, rx_valid, rx_busy, frame_err, overrun}, 0);
    end
    rx = 1'b1;
    @(posedge clk_raw);
    #1;
    rst_n = 1'b1;
    idle(20);
    check("post_rst_busy", rx_busy, 0);
    check("post_rst_valid", rx_valid, 0);

    // Single good frame, then acknowledge.
    push("a5", 0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("a5");
    check("a5_valid_hold", rx_valid, 1);
    check("a5_data_hold", rx_data, 8'hA5);
    ack_pulse();
    check("a5_ack_valid", rx_valid, 0);
    check("a5_ack_data", rx_data, 8'hA5);
    idle(4);

    // False start: two-cycle low pulse.
    push("fstart", 2, 8'h00);
    rx = 1'b0;
    repeat (2) @(posedge clk_raw);
    #1;
    idle(20);
    drain("fstart");
    check("fstart_busy", rx_busy, 0);
    check("fstart_valid", rx_valid, 0);

    // Stop bit low: frame error; the lingering low line then looks like a false start.
    push("ferr3c", 1, 8'h00);
    push("ferr_tail", 2, 8'h00);
    send_frame(8'h3C, 1'b0);
    idle(20);
    drain("ferr3c");
    check("ferr_valid", rx_valid, 0);
    check("ferr_data", rx_data, 8'hA5);

    // Back-to-back frames without ack: overrun.
    push("ovr11", 0, 8'h11);
    push("ovr22", 0, 8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    drain("ovr");
    check("ovr_flag", overrun, 1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_valid", rx_valid, 1);
    ack_pulse();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_flag", overrun, 0);
    idle(4);

    // Reset during data bit 4 of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (3) @(posedge clk_raw);
    #1;
    check("midrst_busy_before", rx_busy, 1);
    rst_n = 1'b0;
    @(posedge clk_raw);
    #1;
    check("midrst_outs", {rx_data, rx_valid, rx_busy, frame_err, overrun}, 0);
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    rst_n   = 1'b1;
    idle(12);
    check("midrst_idle_busy", rx_busy, 0);

    push("5a", 0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    drain("5a");
    check("5a_data", rx_data, 8'h5A);
    check("5a_ovr", overrun, 0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front-end for the Task1 link. It deserializes 8N1 UART frames from the raw `rx` pin into a parallel byte with a level valid/ack handshake. The byte drives the `t0..t7`-style data lines consumed by the receive/display stage, and transmit-side logic reads `rx_busy`/`rx_valid` for its sent/received indication. It sits directly upstream of the display/echo logic and replaces ad-hoc sampling of `rx`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: `clk_raw` cycles per bit (50 MHz / 9600 baud). Must be ≥ 4.

Ports:
- `clk_raw` input 1: single system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: raw serial line, idle high. Asynchronous to `clk_raw`.
- `rx_data` output 8: last good byte; bit 0 is the first data bit received.
- `rx_valid` output 1: high while `rx_data` holds an unacknowledged byte.
- `rx_ack` input 1: consumer acknowledge, sampled each cycle.
- `rx_busy` output 1: high while a frame is in progress (any state other than IDLE).
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: sticky flag; cleared by reset or by `rx_ack`.

## Operation
- Input sync: `rx` passes through a 2-FF synchronizer (`rx_s`). Both FFs reset to 1. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE: when `rx_s` is 0, go to START and load the bit counter `cnt` with 0.
- START: count to `CLKS_PER_BIT/2 - 1` (integer divide).
  - If `rx_s` is 0 at that point, go to DATA with `cnt`=0 and bit index 0.
  - Otherwise it is a false start: return to IDLE with no flags.
- DATA: sample `rx_s` into shift register bit [idx] when `cnt` = `CLKS_PER_BIT-1`, then reset `cnt`.
  - After idx 7 is sampled, go to STOP.
- STOP: sample at `cnt` = `CLKS_PER_BIT-1`, then go to IDLE on the same edge.
  - Stop bit = 1: load `rx_data` from the shift register.
    - If `rx_valid` is already 1 and there is no `rx_ack` in that cycle, set `overrun`. The new byte overwrites the old one and `rx_valid` stays 1.
    - Otherwise set `rx_valid`.
  - Stop bit = 0: pulse `frame_err`. `rx_data`, `rx_valid` and `overrun` are unchanged.
- Handshake:
  - `rx_ack` high while `rx_valid` is 1 clears `rx_valid` on the next edge.
  - If a load occurs in the same cycle as `rx_ack`, the load wins: `rx_valid` stays 1, and `overrun` is cleared, not set.
  - `rx_ack` while `rx_valid` is 0 has no effect except clearing `overrun`.
- Returning to IDLE at the stop-bit midpoint means a back-to-back start edge is caught with no lost frame.
- Counters:
  - `cnt` width is `$clog2(CLKS_PER_BIT)`, and it never exceeds `CLKS_PER_BIT-1`.
  - `idx` is 3 bits and does not wrap past 7.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, shift register=0.
- Reset asserted mid-frame aborts the frame at once. After release the block waits in IDLE for a new falling edge. If `rx` is still low at release, that counts as a start.
- Edge-to-START: a falling edge on `rx` before edge N gives START from edge N+2; `rx_busy` is high from edge N+3.
- Data bit k is sampled about `CLKS_PER_BIT*(k+1.5)` cycles after the start edge. Stop is sampled at about 9.5 bit times.
- `rx_valid` and `frame_err` change on the edge that samples the stop bit. `rx_busy` falls on that same edge.
- `frame_err` is exactly one cycle wide.
- No combinational path from `rx` or `rx_ack` to any output.

## Test plan
Bench uses `CLKS_PER_BIT`=8.
- Reset: hold `rst_n`=0 with `rx` toggling → all outputs 0 and `rx_data`=00. Release → stays idle while `rx`=1.
- Single frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `rx_data`=A5 and `rx_valid`=1 about 76 cycles after the edge, `frame_err`=0. Pulse `rx_ack` → `rx_valid`=0 next cycle, `rx_data` holds A5.
- False start: `rx` low for 2 cycles then high → FSM back to IDLE, `rx_busy` drops, no flags.
- Frame error: 0x3C with stop bit 0 → one-cycle `frame_err`, `rx_valid` stays 0, `rx_data` unchanged.
- Overrun: back-to-back frames 0x11 then 0x22 with no ack → `rx_data`=22, `rx_valid`=1, `overrun`=1. `rx_ack` → both cleared.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of 0xFF → outputs reset. Then a clean 0x5A frame → `rx_data`=5A with no error.
